// File: rtl/inverse_bwt_decoder.sv
// Inverse Burrows-Wheeler transform: rebuilds a string from its BWT last column and primary index by LF-mapping.
// Optional short-cycle detection during the walk is enabled by defining IBWT_CYCLE_CHECK_EN.
module inverse_bwt_decoder #(
  parameter int unsigned STRING_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bwt_string [STRING_LEN-1:0],
  input  logic [7:0] primary_index,
  input  logic       start_decode,
  output logic [7:0] output_string [STRING_LEN-1:0],
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned SYMS     = 256;
  localparam int unsigned IW       = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
  localparam logic [7:0]  LAST_IDX = 8'(STRING_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COUNT, PREFIX, RANK, WALK, DONE} state_t;

  state_t     state, state_next;
  logic       busy_d, done_d;
  logic [7:0] l_reg [STRING_LEN-1:0];
  logic [7:0] lf    [STRING_LEN-1:0];
  logic [7:0] cnt   [SYMS-1:0];
  logic [7:0] c_tab [SYMS-1:0];
  logic [7:0] p0, p, idx, acc;
  logic [IW-1:0] pos;
  logic [7:0] sym;
`ifdef IBWT_CYCLE_CHECK_EN
  logic       uniform;
`endif

  assign pos = IW'(idx);
  assign sym = l_reg[pos];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start_decode) state_next = LOAD;
      LOAD:   state_next = (p0 > LAST_IDX) ? DONE : COUNT;
      COUNT:  if (idx == LAST_IDX) state_next = PREFIX;
      PREFIX: if (idx == 8'hFF) state_next = RANK;
      RANK:   if (idx == LAST_IDX) state_next = WALK;
      WALK:   if (idx == 8'h00) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the upcoming state and registered
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_next != IDLE) busy_d = 1'b1;
    if (state_next == DONE) done_d = 1'b1;
  end

  // Datapath: histogram, prefix sum, rank table and LF walk share one index counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      p0   <= 8'h00;
      p    <= 8'h00;
      idx  <= 8'h00;
      acc  <= 8'h00;
`ifdef IBWT_CYCLE_CHECK_EN
      uniform <= 1'b0;
`endif
      for (int i = 0; i < STRING_LEN; i++) begin
        l_reg[i]         <= 8'h00;
        lf[i]            <= 8'h00;
        output_string[i] <= 8'h00;
      end
      for (int c = 0; c < SYMS; c++) begin
        cnt[c]   <= 8'h00;
        c_tab[c] <= 8'h00;
      end
    end else begin
      busy <= busy_d;
      done <= done_d;
      unique case (state)
        IDLE: begin
          if (start_decode) begin
            l_reg <= bwt_string;
            p0    <= primary_index;
            p     <= primary_index;
            err   <= 1'b0;
            for (int i = 0; i < STRING_LEN; i++) output_string[i] <= 8'h00;
          end
        end
        LOAD: begin
          idx <= 8'h00;
          acc <= 8'h00;
`ifdef IBWT_CYCLE_CHECK_EN
          uniform <= 1'b1;
`endif
          for (int c = 0; c < SYMS; c++) cnt[c] <= 8'h00;
          if (p0 > LAST_IDX) err <= 1'b1;
        end
        COUNT: begin
          cnt[sym] <= cnt[sym] + 8'd1;
`ifdef IBWT_CYCLE_CHECK_EN
          if (sym != l_reg[0]) uniform <= 1'b0;
`endif
          idx <= (idx == LAST_IDX) ? 8'h00 : idx + 8'd1;
        end
        PREFIX: begin
          // cnt[] is cleared here so RANK can reuse it as the occurrence counter
          c_tab[idx] <= acc;
          acc        <= acc + cnt[idx];
          cnt[idx]   <= 8'h00;
          idx        <= idx + 8'd1;
        end
        RANK: begin
          lf[pos]  <= c_tab[sym] + cnt[sym];
          cnt[sym] <= cnt[sym] + 8'd1;
          idx      <= (idx == LAST_IDX) ? LAST_IDX : idx + 8'd1;
        end
        WALK: begin
          output_string[pos] <= l_reg[IW'(p)];
          p                  <= lf[IW'(p)];
`ifdef IBWT_CYCLE_CHECK_EN
          // A uniform string legitimately has an identity LF map, so it is exempt
          if (idx != 8'h00 && lf[IW'(p)] == p0 && !uniform) err <= 1'b1;
`endif
          idx <= idx - 8'd1;
        end
        DONE: idx <= 8'h00;
        default: idx <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_bwt_decoder.sv
// Directed bench for inverse_bwt_decoder: N=4 instance for decoding scenarios, N=32 instance for the index range check.
module tb_inverse_bwt_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bwt4 [3:0];
  logic [7:0] out4 [3:0];
  logic [7:0] pidx4;
  logic       start4, busy4, done4, err4;
  logic [7:0] bwt32 [31:0];
  logic [7:0] out32 [31:0];
  logic [7:0] pidx32;
  logic       start32, busy32, done32, err32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inverse_bwt_decoder #(.STRING_LEN(4)) u4 (
    .clk(clk), .rst(rst), .bwt_string(bwt4), .primary_index(pidx4),
    .start_decode(start4), .output_string(out4), .busy(busy4), .done(done4), .err(err4)
  );

  inverse_bwt_decoder #(.STRING_LEN(32)) u32 (
    .clk(clk), .rst(rst), .bwt_string(bwt32), .primary_index(pidx32),
    .start_decode(start32), .output_string(out32), .busy(busy32), .done(done32), .err(err32)
  );

  // First character of the string literal is element 0
  task automatic load4(input logic [31:0] s);
    for (int i = 0; i < 4; i++) bwt4[i] = s[31-8*i -: 8];
  endtask

  function automatic logic [31:0] got4();
    return {out4[0], out4[1], out4[2], out4[3]};
  endfunction

  // Issues a one-cycle start; lat counts cycles after the start cycle until done (-1 on timeout)
  task automatic run4(input logic [31:0] s, input logic [7:0] p, output int lat);
    @(negedge clk);
    load4(s);
    pidx4  = p;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!done4) lat = -1;
  endtask

  task automatic test_reset();
    logic any;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    any = 1'b0;
    for (int i = 0; i < 4; i++) any |= (out4[i] != 8'h00);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done4); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err4); end
    checks++; if (any !== 1'b0) begin errors++; $display("FAIL reset_out got %h want 0", got4()); end
    rst = 1'b0;
  endtask

  task automatic test_decode_caab();
    int lat;
    run4("caab", 8'd1, lat);
    checks++; if (lat != 270) begin errors++; $display("FAIL caab_latency got %0d want 270", lat); end
    checks++; if (got4() !== "abca") begin errors++; $display("FAIL caab_out got %h want %h", got4(), "abca"); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL caab_err got %b want 0", err4); end
    @(negedge clk);
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL caab_after busy=%b done=%b want 0 0", busy4, done4); end
  endtask

  task automatic test_uniform();
    int lat;
    run4("aaaa", 8'd2, lat);
    checks++; if (got4() !== "aaaa") begin errors++; $display("FAIL uniform_out got %h want %h", got4(), "aaaa"); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL uniform_err got %b want 0", err4); end
  endtask

  task automatic test_periodic();
    int lat;
    logic exp_err;
`ifdef IBWT_CYCLE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run4("abab", 8'd0, lat);
    checks++; if (got4() !== "aaaa") begin errors++; $display("FAIL periodic_out got %h want %h", got4(), "aaaa"); end
    checks++; if (err4 !== exp_err) begin errors++; $display("FAIL periodic_err got %b want %b", err4, exp_err); end
  endtask

  task automatic test_bad_index();
    int lat;
    logic any;
    @(negedge clk);
    for (int i = 0; i < 32; i++) bwt32[i] = 8'h61 + 8'(i % 3);
    pidx32  = 8'd40;
    start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!done32) lat = -1;
    any = 1'b0;
    for (int i = 0; i < 32; i++) any |= (out32[i] != 8'h00);
    checks++; if (lat != 2) begin errors++; $display("FAIL bad_index_latency got %0d want 2", lat); end
    checks++; if (err32 !== 1'b1) begin errors++; $display("FAIL bad_index_err got %b want 1", err32); end
    checks++; if (any !== 1'b0) begin errors++; $display("FAIL bad_index_out got nonzero want 0"); end
  endtask

  task automatic test_restart_mid_rank();
    int lat;
    int extra;
    @(negedge clk);
    load4("caab");
    pidx4  = 8'd0;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 263) begin
        load4("aaaa");
        pidx4  = 8'd1;
        start4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
    end
    if (!done4) lat = -1;
    checks++; if (lat != 270) begin errors++; $display("FAIL restart_latency got %0d want 270", lat); end
    checks++; if (got4() !== "aabc") begin errors++; $display("FAIL restart_out got %h want %h", got4(), "aabc"); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL restart_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_walk();
    int lat;
    logic any;
    @(negedge clk);
    load4("caab");
    pidx4  = 8'd1;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (lat < 268) begin
      @(negedge clk);
      lat++;
    end
    rst = 1'b1;
    @(negedge clk);
    any = 1'b0;
    for (int i = 0; i < 4; i++) any |= (out4[i] != 8'h00);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done4); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL midreset_err got %b want 0", err4); end
    checks++; if (any !== 1'b0) begin errors++; $display("FAIL midreset_out got %h want 0", got4()); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL midreset_idle busy got %b want 0", busy4); end
    run4("caab", 8'd1, lat);
    checks++; if (lat != 270) begin errors++; $display("FAIL post_reset_latency got %0d want 270", lat); end
    checks++; if (got4() !== "abca") begin errors++; $display("FAIL post_reset_out got %h want %h", got4(), "abca"); end
  endtask

  initial begin
    start4  = 1'b0;
    start32 = 1'b0;
    pidx4   = 8'h00;
    pidx32  = 8'h00;
    for (int i = 0; i < 4; i++) bwt4[i] = 8'h00;
    for (int i = 0; i < 32; i++) bwt32[i] = 8'h00;
    test_reset();
    test_decode_caab();
    test_uniform();
    test_periodic();
    test_bad_index();
    test_restart_mid_rank();
    test_reset_mid_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inverse_bwt_decoder.md
Name: inverse_bwt_decoder

Overview:
- Inverse Burrows-Wheeler transform. Takes a rotation-sorted BWT last column plus its primary index, and rebuilds the original string by LF-mapping.
- Sits downstream of the forward BWT top and uses the same string and array conventions: 8-bit symbols, unpacked [STRING_LEN-1:0] arrays, start pulse in, done pulse out.
- Implementation is fully sequential: histogram, prefix sum, rank table, then walk.

Parameters:
- STRING_LEN, 32, symbol count of input and output strings; legal range 2..255 (8-bit indices and counts).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- bwt_string  input  [7:0] x STRING_LEN  BWT last column L[0..N-1]; sampled only on accepted start
- primary_index  input  8  row of the sorted rotation matrix equal to the original string; sampled with bwt_string
- start_decode  input  1  start request; honoured only in IDLE
- output_string  output  [7:0] x STRING_LEN  decoded string; held until next accepted start or reset
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, high while in DONE
- err  output  1  valid on the done pulse; held until next accepted start

Behaviour:
- Reset: every output is 0 (output_string all 8'h0, busy, done, err). State goes to IDLE; histogram, prefix, rank and walk registers are cleared. Reset mid-operation aborts the decode immediately, with no done pulse.
- States run IDLE -> LOAD -> COUNT -> PREFIX -> RANK -> WALK -> DONE -> IDLE.
- IDLE:
  - start_decode=1 latches bwt_string into L[] and primary_index into p0. output_string and err clear to 0. Next state is LOAD.
  - start_decode while busy is ignored, with no effect.
- LOAD (1 cycle):
  - Clears cnt[0..255].
  - If p0 >= STRING_LEN: err <= 1, go to DONE. output_string stays 0.
  - Otherwise go to COUNT.
- COUNT (N cycles, i=0..N-1): cnt[L[i]] += 1.
- PREFIX (256 cycles, c=0..255): C[c] = sum of cnt[0..c-1], built with a running accumulator; cnt[c] is then cleared for reuse as the occurrence counter.
- RANK (N cycles, i=0..N-1):
  - LF[i] = C[L[i]] + occ[L[i]]; occ[L[i]] += 1.
  - All sums are 8-bit; they cannot exceed N-1.
- WALK (N cycles, j = N-1 down to 0):
  - output_string[j] <= L[p]; p <= LF[p]; p starts at p0.
- DONE (1 cycle): done=1; busy=0 on the next cycle.
- Latency: done is high exactly 3*STRING_LEN+258 cycles after the cycle in which start is sampled. The invalid-index path instead pulses done 2 cycles after start.
- start_decode high during DONE is ignored; it is accepted in IDLE on the following cycle if still high.
- A uniform string, e.g. all 8'h61, is legal: LF is the identity and any primary index below N decodes to the same string.

Optional Feature:
- IBWT_CYCLE_CHECK_EN defined:
  - During WALK, after step k for k=1..N-1, if the updated p equals p0, set err <= 1. The LF cycle is then shorter than N, so the input is not a valid BWT.
  - The walk still completes, output_string holds the partial/periodic result, and latency is unchanged.
- Not defined: err reflects only the primary_index range check; no check logic is synthesised.

Test Plan:
- N=4, bwt_string="caab" (L[0]='c', L[1]='a', L[2]='a', L[3]='b'), primary_index=1 -> done at cycle 270; output_string="abca" (out[0]='a' .. out[3]='a'); err=0.
- N=4, bwt_string="aaaa", primary_index=2 -> output_string="aaaa"; err=0 with and without IBWT_CYCLE_CHECK_EN.
- N=4, bwt_string="abab", primary_index=0:
  - With IBWT_CYCLE_CHECK_EN: err=1 on the done pulse, output_string="aaaa".
  - Without it: err=0 and the same output.
- primary_index=8'd40 with N=32 -> done 2 cycles after start, err=1, output_string all 0.
- Start accepted, then start_decode re-pulsed mid-RANK -> ignored; single done and correct result.
- Then rst asserted mid-WALK -> next cycle all outputs 0 and state IDLE. A new start then decodes correctly.
